uart_loader: RTL and testbench



---
 rtl/uart_loader_if.sv | 22 ++
 rtl/uart_loader.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_if.sv
// Bus-side signal bundle of the UART program loader: serial input plus the
// RAM write strobes, shared-bus drive and CPU halt/status outputs.
interface uart_loader_if;
  logic        rx;
  logic [15:0] bus_out;
  logic        bus_en;
  logic        mar_load;
  logic        ram_load;
  logic        cpu_halt;
  logic        done;
  logic        err;

  modport master (
    input  rx,
    output bus_out, bus_en, mar_load, ram_load, cpu_halt, done, err
  );

  modport slave (
    output rx,
    input  bus_out, bus_en, mar_load, ram_load, cpu_halt, done, err
  );
endinterface

// File: rtl/uart_loader.sv
// Serial program loader: UART RX -> framed image -> 16-bit word RAM via shared bus.
// Optional LOADER_CHECKSUM_EN appends a 16-bit big-endian sum check after the data words.
module uart_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH        = 4096,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_loader_if.master lb
);

  localparam int HALF   = CLKS_PER_BIT / 2;
  localparam int TMR_W  = $clog2(CLKS_PER_BIT);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W   = $clog2(TO_CYC);
  // One bit wider than the 12-bit RAM address so N=4096 terminates exactly.
  localparam int CNT_W  = 13;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  typedef enum logic [3:0] {
    IDLE, CNT_LO, DATA_HI, DATA_LO, WR_ADDR, WR_DATA,
`ifdef LOADER_CHECKSUM_EN
    CHK_HI, CHK_LO,
`endif
    DONE
  } state_t;

  // ---------------- RX front end ----------------
  logic             rx_s1, rx_s2, rx_d;
  rx_state_t        rs, rs_nxt;
  logic [TMR_W-1:0] bit_tmr;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_sh;
  logic             tmr_clr, shift_en, stop_ok, stop_bad;
  logic             byte_valid, frame_err;
  logic             rx_fall;

  assign rx_fall = rx_d & ~rx_s2;

  always_comb begin
    rs_nxt   = rs;
    tmr_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (rs)
      R_IDLE: begin
        tmr_clr = 1'b1;
        if (rx_fall) rs_nxt = R_START;
      end
      R_START: begin
        if (bit_tmr == TMR_W'(HALF - 1)) begin
          tmr_clr = 1'b1;
          rs_nxt  = rx_s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (bit_tmr == TMR_W'(CLKS_PER_BIT - 1)) begin
          tmr_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) rs_nxt = R_STOP;
        end
      end
      R_STOP: begin
        if (bit_tmr == TMR_W'(CLKS_PER_BIT - 1)) begin
          tmr_clr = 1'b1;
          rs_nxt  = R_IDLE;
          if (rx_s2) stop_ok  = 1'b1;
          else       stop_bad = 1'b1;
        end
      end
      default: rs_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_d       <= 1'b1;
      rs         <= R_IDLE;
      bit_tmr    <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= lb.rx;
      rx_s2      <= rx_s1;
      rx_d       <= rx_s2;
      rs         <= rs_nxt;
      bit_tmr    <= tmr_clr ? '0 : bit_tmr + TMR_W'(1);
      byte_valid <= stop_ok;
      frame_err  <= stop_bad;
      if (rs == R_START)  bit_idx <= '0;
      else if (shift_en)  bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) rx_sh <= {rx_s2, rx_sh[7:1]};
  end

  // ---------------- Frame FSM ----------------
  state_t           state, state_nxt;
  logic [CNT_W-1:0] addr, n;
  logic [7:0]       cnt_hi, word_hi;
  logic [15:0]      word;
  logic [15:0]      n_word;
  logic [TO_W-1:0]  to_cnt;
  logic             err;
  logic             timed, to_expired;
  logic             ld_cnt_hi, ld_n, ld_hi, ld_lo, addr_inc, err_set, err_clr;
  logic [15:0]      bus_out_c;
  logic             bus_en_c, mar_load_c, ram_load_c, cpu_halt_c, done_c;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       chk_hi;
  logic [15:0]      sum;
  logic             ld_chk_hi;
`endif

  assign n_word     = {cnt_hi, rx_sh};
  assign to_expired = timed && (rs == R_IDLE) && !rx_fall &&
                      (to_cnt == TO_W'(TO_CYC - 1));

  always_comb begin
    state_nxt  = state;
    ld_cnt_hi  = 1'b0;
    ld_n       = 1'b0;
    ld_hi      = 1'b0;
    ld_lo      = 1'b0;
    addr_inc   = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    timed      = 1'b0;
    bus_out_c  = '0;
    bus_en_c   = 1'b0;
    mar_load_c = 1'b0;
    ram_load_c = 1'b0;
    cpu_halt_c = 1'b0;
    done_c     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    ld_chk_hi  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (byte_valid) begin
          ld_cnt_hi = 1'b1;
          err_clr   = 1'b1;
          state_nxt = CNT_LO;
        end
      end
      CNT_LO: begin
        cpu_halt_c = 1'b1;
        timed      = 1'b1;
        if (byte_valid) begin
          if (n_word == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_nxt = CHK_HI;
`else
            state_nxt = DONE;
`endif
          end else if (n_word > 16'(DEPTH)) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ld_n      = 1'b1;
            state_nxt = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        cpu_halt_c = 1'b1;
        timed      = 1'b1;
        if (byte_valid) begin
          ld_hi     = 1'b1;
          state_nxt = DATA_LO;
        end
      end
      DATA_LO: begin
        cpu_halt_c = 1'b1;
        timed      = 1'b1;
        if (byte_valid) begin
          ld_lo     = 1'b1;
          state_nxt = WR_ADDR;
        end
      end
      WR_ADDR: begin
        cpu_halt_c = 1'b1;
        bus_en_c   = 1'b1;
        mar_load_c = 1'b1;
        bus_out_c  = {4'b0, addr[11:0]};
        state_nxt  = WR_DATA;
      end
      WR_DATA: begin
        cpu_halt_c = 1'b1;
        bus_en_c   = 1'b1;
        ram_load_c = 1'b1;
        bus_out_c  = word;
        addr_inc   = 1'b1;
        if (addr + CNT_W'(1) == n) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CHK_HI;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = DATA_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK_HI: begin
        cpu_halt_c = 1'b1;
        timed      = 1'b1;
        if (byte_valid) begin
          ld_chk_hi = 1'b1;
          state_nxt = CHK_LO;
        end
      end
      CHK_LO: begin
        cpu_halt_c = 1'b1;
        timed      = 1'b1;
        if (byte_valid) begin
          if ({chk_hi, rx_sh} == sum) begin
            state_nxt = DONE;
          end else begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
`endif
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A bad stop bit or a stalled sender abandons the frame from any state.
    if (frame_err || to_expired) begin
      err_set   = 1'b1;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      n      <= '0;
      err    <= 1'b0;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= (!timed || rs != R_IDLE || rx_fall) ? '0 : to_cnt + TO_W'(1);
      if (ld_cnt_hi)     addr <= '0;
      else if (addr_inc) addr <= addr + CNT_W'(1);
      if (ld_n) n <= n_word[CNT_W-1:0];
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_cnt_hi) cnt_hi  <= rx_sh;
    if (ld_hi)     word_hi <= rx_sh;
    if (ld_lo)     word    <= {word_hi, rx_sh};
`ifdef LOADER_CHECKSUM_EN
    if (ld_chk_hi)  chk_hi <= rx_sh;
    if (ld_cnt_hi)  sum    <= '0;
    else if (ld_lo) sum    <= sum + {word_hi, rx_sh};
`endif
  end

  assign lb.bus_out  = bus_out_c;
  assign lb.bus_en   = bus_en_c;
  assign lb.mar_load = mar_load_c;
  assign lb.ram_load = ram_load_c;
  assign lb.cpu_halt = cpu_halt_c;
  assign lb.done     = done_c;
  assign lb.err      = err;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: directed UART frames, expected bus events queued
// by the stimulus and popped by an independent monitor.
module tb_uart_loader;
  localparam int CPB = 4;
  localparam logic [1:0] K_MAR = 2'd0, K_RAM = 2'd1, K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_loader_if bus ();

  uart_loader #(.CLKS_PER_BIT(CPB), .DEPTH(4096), .TIMEOUT_BITS(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lb    (bus)
  );

  ev_t        exp_q[$];
  logic [7:0] tx_q[$];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic exp_write(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back('{kind: K_MAR, val: a});
    exp_q.push_back('{kind: K_RAM, val: d});
  endtask

  task automatic exp_done();
    exp_q.push_back('{kind: K_DONE, val: 16'h0});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_q();
    while (tx_q.size() != 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (6) @(negedge clk);
  endtask

  // Monitor: every strobe the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      check("bus_en_gate", {31'd0, bus.bus_en}, {31'd0, bus.mar_load | bus.ram_load});
      if (bus.mar_load && bus.ram_load) check("strobe_overlap", 32'd1, 32'd0);
      if (bus.mar_load || bus.ram_load || bus.done) begin
        ev_t        e;
        logic [1:0] k;
        k = bus.mar_load ? K_MAR : (bus.ram_load ? K_RAM : K_DONE);
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, k}, 32'h3);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {30'd0, k}, {30'd0, e.kind});
          if (k == K_DONE) begin
            check("done_halt_low", {31'd0, bus.cpu_halt}, 32'd0);
            check("done_err_low", {31'd0, bus.err}, 32'd0);
          end else begin
            check("event_bus", {16'd0, bus.bus_out}, {16'd0, e.val});
            check("write_halt_high", {31'd0, bus.cpu_halt}, 32'd1);
          end
        end
      end
    end
  end

  function automatic logic [31:0] outs_vec();
    return {9'd0, bus.bus_out, bus.bus_en, bus.mar_load, bus.ram_load,
            bus.cpu_halt, bus.done, bus.err};
  endfunction

  initial begin
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_vec(), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: two words
    exp_write(16'h0000, 16'h1234);
    exp_write(16'h0001, 16'hABCD);
    exp_done();
    send_byte(8'h00, 1'b1);
    check("t1_halt_after_first", {31'd0, bus.cpu_halt}, 32'd1);
    tx_q = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'hBE);
    tx_q.push_back(8'h01);
`endif
    send_q();
    wait_drain("t1_drain");
    check("t1_err", {31'd0, bus.err}, 32'd0);
    check("t1_halt_end", {31'd0, bus.cpu_halt}, 32'd0);

    // 2: empty image
    exp_done();
`ifdef LOADER_CHECKSUM_EN
    tx_q = {8'h00, 8'h00, 8'h00, 8'h00};
`else
    tx_q = {8'h00, 8'h00};
`endif
    send_q();
    wait_drain("t2_drain");
    check("t2_err", {31'd0, bus.err}, 32'd0);

    // 3: oversize count, then a good frame
    tx_q = {8'h10, 8'h01};
    send_q();
    repeat (10) @(negedge clk);
    check("t3_err_set", {31'd0, bus.err}, 32'd1);
    check("t3_halt_low", {31'd0, bus.cpu_halt}, 32'd0);
    exp_write(16'h0000, 16'h0005);
    exp_done();
    tx_q = {8'h00, 8'h01, 8'h00, 8'h05};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h05);
`endif
    send_q();
    wait_drain("t3_drain");
    check("t3_err_clear", {31'd0, bus.err}, 32'd0);

    // 4: framing error, glitch, good frame
    tx_q = {8'h00, 8'h02};
    send_q();
    send_byte(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    check("t4_frame_err", {31'd0, bus.err}, 32'd1);
    check("t4_halt_low", {31'd0, bus.cpu_halt}, 32'd0);
    bus.rx = 1'b0;
    repeat (2) @(negedge clk);
    bus.rx = 1'b1;
    repeat (60) @(negedge clk);
    check("t4_glitch_err_kept", {31'd0, bus.err}, 32'd1);
    check("t4_glitch_no_halt", {31'd0, bus.cpu_halt}, 32'd0);
    exp_write(16'h0000, 16'hFFFF);
    exp_done();
    tx_q = {8'h00, 8'h01, 8'hFF, 8'hFF};
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'hFF);
`endif
    send_q();
    wait_drain("t4_drain");
    check("t4_err_clear", {31'd0, bus.err}, 32'd0);

    // 5a: sender stalls after one of three words
    exp_write(16'h0000, 16'h0001);
    tx_q = {8'h00, 8'h03, 8'h00, 8'h01};
    send_q();
    wait_drain("t5_drain");
    check("t5_halt_before_timeout", {31'd0, bus.cpu_halt}, 32'd1);
    repeat (300) @(negedge clk);
    check("t5_timeout_err", {31'd0, bus.err}, 32'd1);
    check("t5_timeout_halt", {31'd0, bus.cpu_halt}, 32'd0);

    // 5b: reset while waiting for a low byte
    exp_write(16'h0000, 16'h1234);
    tx_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_q();
    wait_drain("t5b_drain");
    check("t5b_halt_mid", {31'd0, bus.cpu_halt}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5b_reset_outputs", outs_vec(), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum match and mismatch
    exp_write(16'h0000, 16'h0001);
    exp_write(16'h0001, 16'h0002);
    exp_done();
    tx_q = {8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    send_q();
    wait_drain("t6_drain");
    check("t6_err", {31'd0, bus.err}, 32'd0);
    exp_write(16'h0000, 16'h0001);
    exp_write(16'h0001, 16'h0002);
    tx_q = {8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04};
    send_q();
    wait_drain("t6b_drain");
    check("t6b_err", {31'd0, bus.err}, 32'd1);
    check("t6b_halt", {31'd0, bus.cpu_halt}, 32'd0);
`endif

    repeat (10) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
